// File: rtl/controle_horner_if.sv
// Handshake and control bundle between the Horner controller and its requester/datapath.
// The controller sits on the slave side; the requester drives start/grau from the master side.
interface controle_horner_if;
  logic       start;
  logic [1:0] grau;
  logic       lx;
  logic       ls;
  logic       lh;
  logic [1:0] m0;
  logic [1:0] m1;
  logic [1:0] m2;
  logic       h;
  logic       done;
  logic       busy;

  modport master (
    output start, grau,
    input  lx, ls, lh, m0, m1, m2, h, done, busy
  );

  modport slave (
    input  start, grau,
    output lx, ls, lh, m0, m1, m2, h, done, busy
  );
endinterface

// File: rtl/controle_horner.sv
// Moore controller sequencing a Horner-scheme polynomial evaluation (degree 0..2)
// over an external X/S/H register datapath with a shared add/multiply ULA.
module controle_horner (
  input logic              ck,
  input logic              rst,
  controle_horner_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, LOADX, CLRH, MUL1, ADD1, MUL2, ADD2, DONE
  } state_t;

  typedef struct packed {
    logic       lx;
    logic       ls;
    logic       lh;
    logic [1:0] m0;
    logic [1:0] m1;
    logic [1:0] m2;
    logic       h;
    logic       done;
    logic       busy;
  } ctrl_t;

  state_t     state;
  state_t     next_state;
  logic [1:0] degree;
  logic [1:0] next_degree;
  ctrl_t      ctrl;

  // Output pattern of each state; degree only picks the first coefficient in MUL1.
  function automatic ctrl_t decode(input state_t s, input logic [1:0] deg);
    ctrl_t c;
    c      = '0;
    c.busy = (s != IDLE);
    case (s)
      LOADX: c.lx = 1'b1;
      CLRH: begin
        c.m2 = 2'b01;
        c.lh = 1'b1;
      end
      MUL1: begin
        c.m0 = (deg == 2'd2) ? 2'b01 : 2'b10;
        c.h  = 1'b1;
        c.lh = 1'b1;
      end
      ADD1: begin
        c.m0 = 2'b10;
        c.m1 = 2'b11;
        c.m2 = 2'b01;
        c.lh = 1'b1;
      end
      MUL2: begin
        c.m1 = 2'b11;
        c.h  = 1'b1;
        c.lh = 1'b1;
      end
      ADD2: begin
        c.m0 = 2'b11;
        c.m1 = 2'b11;
        c.m2 = 2'b01;
        c.ls = 1'b1;
      end
      DONE:    c.done = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    next_state  = IDLE;
    next_degree = degree;
    case (state)
      IDLE: begin
        if (bus.start) begin
          next_state  = LOADX;
          next_degree = (bus.grau == 2'b11) ? 2'd2 : bus.grau;
        end else begin
          next_state = IDLE;
        end
      end
      LOADX:   next_state = (degree == 2'd0) ? CLRH : MUL1;
      CLRH:    next_state = ADD2;
      MUL1:    next_state = (degree == 2'd2) ? ADD1 : ADD2;
      ADD1:    next_state = MUL2;
      MUL2:    next_state = ADD2;
      ADD2:    next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      degree <= 2'd0;
      ctrl   <= '0;
    end else begin
      state  <= next_state;
      degree <= next_degree;
      ctrl   <= decode(next_state, next_degree);
    end
  end

  assign bus.lx   = ctrl.lx;
  assign bus.ls   = ctrl.ls;
  assign bus.lh   = ctrl.lh;
  assign bus.m0   = ctrl.m0;
  assign bus.m1   = ctrl.m1;
  assign bus.m2   = ctrl.m2;
  assign bus.h    = ctrl.h;
  assign bus.done = ctrl.done;
  assign bus.busy = ctrl.busy;

endmodule

// File: tb/tb_controle_horner.sv
// Bench for controle_horner: an evaluation-level model (phase counter plus the polynomial value)
// checks the control pattern every cycle and the result of an X/S/H datapath steered by the DUT.
module tb_controle_horner;

  logic ck = 1'b0;
  logic rst;

  controle_horner_if bus ();

  controle_horner dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  always #5 ck = ~ck;

  int vectors     = 0;
  int miscompares = 0;
  int done_seen   = 0;

  int a, b, c, nx;
  int xm, sm, hm;

  bit idle = 1'b1;
  int k, len, deg, poly_e;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Expected control pattern from the position k within an evaluation of length len.
  task automatic checkCycle();
    logic [5:0] e;
    e = '0;
    if (!idle) begin
      e[5] = 1'b1;
      e[4] = (k == len);
      e[3] = (k == 1);
      e[2] = (k == len - 1);
      e[1] = (k >= 2) && (k <= len - 2);
      e[0] = (deg != 0) && ((k == 2) || (deg == 2 && k == 4));
    end
    checkOutput("ctrl", {26'd0, bus.busy, bus.done, bus.lx, bus.ls, bus.lh, bus.h}, {26'd0, e});
    if (idle)
      checkOutput("idle_mux", {26'd0, bus.m0, bus.m1, bus.m2}, 32'd0);
    if (!idle && k == len)
      checkOutput("result", sm, poly_e);
  endtask

  task automatic applyStimulus(input bit st, input logic [1:0] g);
    int o, i1, i2, u;
    checkCycle();
    if (bus.done) done_seen++;
    bus.start = st;
    bus.grau  = g;
    case (bus.m0)
      2'b00: o = 0;
      2'b01: o = a;
      2'b10: o = b;
      default: o = c;
    endcase
    case (bus.m1)
      2'b00: i1 = o;
      2'b01: i1 = xm;
      2'b10: i1 = sm;
      default: i1 = hm;
    endcase
    case (bus.m2)
      2'b00: i2 = xm;
      2'b01: i2 = o;
      2'b10: i2 = sm;
      default: i2 = hm;
    endcase
    u = bus.h ? i1 * i2 : i1 + i2;
    if (bus.lx) xm = nx;
    if (bus.lh) hm = u;
    if (bus.ls) sm = u;
    @(posedge ck);
    if (idle) begin
      if (st) begin
        idle   = 1'b0;
        k      = 1;
        deg    = (g == 2'b11) ? 2 : int'(g);
        len    = (deg == 2) ? 6 : 4;
        poly_e = (deg == 2) ? a * nx * nx + b * nx + c : (deg == 1) ? b * nx + c : c;
      end
    end else if (k == len) begin
      idle = 1'b1;
    end else begin
      k++;
    end
    @(negedge ck);
  endtask

  task automatic runEval(input logic [1:0] g, input int cycles);
    applyStimulus(1'b1, g);
    repeat (cycles) applyStimulus(1'b0, 2'($urandom));
  endtask

  // Asserted between edges so the clear must not wait for a clock.
  task automatic asyncReset();
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst",
                {20'd0, bus.busy, bus.done, bus.lx, bus.ls, bus.lh, bus.h, bus.m0, bus.m1, bus.m2},
                32'd0);
    idle = 1'b1;
    xm = 0; sm = 0; hm = 0;
    @(posedge ck);
    @(negedge ck);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.grau  = 2'b00;
    xm = 0; sm = 0; hm = 0;
    a = 2; b = 3; c = 4; nx = 5;
    #1;
    checkOutput("reset",
                {20'd0, bus.busy, bus.done, bus.lx, bus.ls, bus.lh, bus.h, bus.m0, bus.m1, bus.m2},
                32'd0);
    @(negedge ck);
    rst = 1'b0;

    runEval(2'b10, 7);
    checkOutput("deg2_value", sm, 32'd69);
    runEval(2'b01, 5);
    checkOutput("deg1_value", sm, 32'd19);
    runEval(2'b00, 5);
    checkOutput("deg0_value", sm, 32'd4);
    runEval(2'b11, 7);
    checkOutput("grau11_value", sm, 32'd69);

    // Second start during MUL2 with grau=00 must be ignored.
    done_seen = 0;
    applyStimulus(1'b1, 2'b10);
    repeat (3) applyStimulus(1'b0, 2'b10);
    applyStimulus(1'b1, 2'b00);
    repeat (4) applyStimulus(1'b0, 2'b00);
    checkOutput("ignored_start_done", done_seen, 32'd1);
    checkOutput("ignored_start_value", sm, 32'd69);

    // Reset during ADD1, then a fresh degree-2 run with X=2.
    applyStimulus(1'b1, 2'b10);
    applyStimulus(1'b0, 2'b10);
    applyStimulus(1'b0, 2'b10);
    done_seen = 0;
    asyncReset();
    checkOutput("abort_no_done", done_seen, 32'd0);
    nx = 2;
    runEval(2'b10, 7);
    checkOutput("after_rst_value", sm, 32'd18);

    // start held high with degree 1: done every 5 cycles.
    nx = 5;
    done_seen = 0;
    repeat (20) applyStimulus(1'b1, 2'b01);
    checkOutput("held_start_dones", done_seen, 32'd4);
    repeat (6) applyStimulus(1'b0, 2'b00);

    for (int i = 0; i < 400; i++) begin
      if (idle) begin
        a  = $urandom_range(0, 15);
        b  = $urandom_range(0, 15);
        c  = $urandom_range(0, 15);
        nx = $urandom_range(0, 15);
      end
      applyStimulus(($urandom_range(0, 3) == 0), 2'($urandom));
    end
    repeat (8) applyStimulus(1'b0, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
